// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit period and data width.
// The default bit period is also used by uart_tx, so both ends use the same timing.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_rx_state_e;

    // round(100 MHz / 9600)
    localparam int UART_CLKS_PER_BIT = 10417;
    localparam int UART_DATA_W       = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the RX pin, plus an optional 2-of-3 majority filter
// used at sample points when UART_RX_MAJORITY_EN is defined.
`timescale 1ns/1ps
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic rx_smp
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], rx};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    // Two previous rx_s values; together with rx_s they form the 3-sample vote.
    logic [1:0] hist_q;
    logic [1:0] hist_d;

    always_comb begin
        hist_d = {hist_q[0], rx_s};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign rx_smp = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign rx_smp = rx_s;
`endif

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit validation, mid-bit sampling, framing-error detection.
// Optional glitch filter on sample points via the UART_RX_MAJORITY_EN macro.
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   RX,
    output logic [UART_DATA_W-1:0] DATA,
    output logic                   VALID,
    output logic                   FRAME_ERR,
    output logic                   BUSY
);

    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0] HALF_M1 = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0] FULL_M1 = TMR_W'(CLKS_PER_BIT - 1);

    logic rx_s;
    logic rx_smp;

    uart_rx_sync u_sync (
        .clk    (CLK),
        .rst_n  (RST_N),
        .rx     (RX),
        .rx_s   (rx_s),
        .rx_smp (rx_smp)
    );

    uart_rx_state_e         state_q,     state_d;
    logic [TMR_W-1:0]       bit_tmr_q,   bit_tmr_d;
    logic [2:0]             bit_idx_q,   bit_idx_d;
    logic [UART_DATA_W-1:0] shreg_q,     shreg_d;
    logic [UART_DATA_W-1:0] data_q,      data_d;
    logic                   valid_q,     valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   busy_q,      busy_d;

    always_comb begin
        state_d     = state_q;
        bit_tmr_d   = bit_tmr_q + TMR_W'(1);
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bit_tmr_d = '0;
                bit_idx_d = '0;
                if (!rx_s) state_d = ST_START;
            end
            ST_START: begin
                if (bit_tmr_q == HALF_M1) begin
                    bit_tmr_d = '0;
                    state_d   = rx_smp ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tmr_q == FULL_M1) begin
                    bit_tmr_d          = '0;
                    shreg_d[bit_idx_q] = rx_smp;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
                if (bit_tmr_q == FULL_M1) begin
                    bit_tmr_d = '0;
                    if (rx_smp) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                bit_tmr_d = '0;
                if (rx_s) state_d = ST_IDLE;
            end
            default: begin
                bit_tmr_d = '0;
                state_d   = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            bit_tmr_q   <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_tmr_q   <= bit_tmr_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign DATA      = data_q;
    assign VALID     = valid_q;
    assign FRAME_ERR = frame_err_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit; expected frames are queued
// by the stimulus and checked by an independent monitor on each output pulse.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB = 16;

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b0;
    logic       RX    = 1'b1;
    logic [7:0] DATA;
    logic       VALID;
    logic       FRAME_ERR;
    logic       BUSY;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .RX        (RX),
        .DATA      (DATA),
        .VALID     (VALID),
        .FRAME_ERR (FRAME_ERR),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q[$];
    int         errors    = 0;
    int         checks    = 0;
    logic [7:0] last_good = 8'h00;
    bit         mon_en    = 1'b0;
    logic [7:0] glitch_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_good(input logic [7:0] b);
        sb_q.push_back('{err: 1'b0, data: b});
        last_good = b;
    endtask

    task automatic expect_ferr();
        sb_q.push_back('{err: 1'b1, data: last_good});
    endtask

    // One bit period; optional one-cycle inversion exactly at the DUT sample point.
    task automatic drive_bit(input logic v, input bit glitch);
        RX = v;
        repeat (CPB / 2) @(negedge CLK);
        if (glitch) RX = ~v;
        @(negedge CLK);
        RX = v;
        repeat (CPB / 2 - 1) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input bit glitch);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i], glitch);
        drive_bit(stop, 1'b0);
    endtask

    task automatic idle_bits(input int n);
        RX = 1'b1;
        repeat (n * CPB) @(negedge CLK);
    endtask

    // Monitor: every output pulse must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (mon_en && (VALID || FRAME_ERR)) begin
            exp_t e;
            chk("valid_ferr_exclusive", 32'(VALID & FRAME_ERR), 32'd0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: VALID=%b FRAME_ERR=%b DATA=%h, expected no pulse (t=%0t)",
                         VALID, FRAME_ERR, DATA, $time);
            end else begin
                e = sb_q.pop_front();
                chk("pulse_is_ferr", 32'(FRAME_ERR), 32'(e.err));
                chk("data", 32'(DATA), 32'(e.data));
                chk("busy_at_pulse", 32'(BUSY), 32'(e.err));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_data", 32'(DATA), 32'h00);
        chk("rst_valid", 32'(VALID), 32'd0);
        chk("rst_ferr", 32'(FRAME_ERR), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        RST_N  = 1'b1;
        mon_en = 1'b1;
        idle_bits(2);

        // Single good frame
        expect_good(8'hA5);
        send_byte(8'hA5, 1'b1, 1'b0);
        idle_bits(2);
        chk("a5_busy_idle", 32'(BUSY), 32'd0);
        chk("a5_data_hold", 32'(DATA), 32'hA5);

        // Back-to-back frames, zero idle gap
        expect_good(8'h00);
        send_byte(8'h00, 1'b1, 1'b0);
        expect_good(8'hFF);
        send_byte(8'hFF, 1'b1, 1'b0);
        expect_good(8'h3C);
        send_byte(8'h3C, 1'b1, 1'b0);
        idle_bits(2);

        // Short low glitch: START entered then abandoned
        RX = 1'b0;
        repeat (3) @(negedge CLK);
        RX = 1'b1;
        chk("glitch_busy_start", 32'(BUSY), 32'd1);
        repeat (20) @(negedge CLK);
        chk("glitch_busy_idle", 32'(BUSY), 32'd0);
        chk("glitch_data_hold", 32'(DATA), 32'h3C);
        idle_bits(1);

        // Framing error followed by a long break
        expect_ferr();
        send_byte(8'h55, 1'b0, 1'b0);
        RX = 1'b0;
        repeat (40 * CPB) @(negedge CLK);
        chk("break_busy", 32'(BUSY), 32'd1);
        chk("break_data_hold", 32'(DATA), 32'h3C);
        idle_bits(2);
        chk("break_released_idle", 32'(BUSY), 32'd0);
        expect_good(8'h12);
        send_byte(8'h12, 1'b1, 1'b0);
        idle_bits(2);

        // Reset during data bit 4
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h5A >> i), 1'b0);
        RX = 1'b1;
        repeat (CPB / 2) @(negedge CLK);
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        chk("midrst_data", 32'(DATA), 32'h00);
        chk("midrst_valid", 32'(VALID), 32'd0);
        chk("midrst_ferr", 32'(FRAME_ERR), 32'd0);
        chk("midrst_busy", 32'(BUSY), 32'd0);
        RST_N     = 1'b1;
        last_good = 8'h00;
        idle_bits(20);
        chk("midrst_stays_idle", 32'(BUSY), 32'd0);
        expect_good(8'hC3);
        send_byte(8'hC3, 1'b1, 1'b0);
        idle_bits(2);

        // One-cycle inversions at every data-bit sample point
`ifdef UART_RX_MAJORITY_EN
        glitch_exp = 8'h96;
`else
        glitch_exp = 8'h69;
`endif
        expect_good(glitch_exp);
        send_byte(8'h96, 1'b1, 1'b1);
        idle_bits(2);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        chk("final_data", 32'(DATA), 32'(glitch_exp));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the board's 8N1 UART link, the receiving end of the existing `uart_tx` transmitter. It synchronises the asynchronous `RX` pin, detects and validates the start bit, and samples each bit at mid-bit using the same 100 MHz / 9600 baud bit timing as `uart_tx`. It presents each received byte on `DATA` with a one-cycle `VALID` strobe, for use by the processor I/O logic and UART test harness.

## Interface
- `CLKS_PER_BIT`, default 10417: `CLK` cycles per bit, round(100 MHz / 9600). Matches the `uart_tx` bit period. Legal range ≥ 8.
- `CLK`  in  1  system clock, 100 MHz.
- `RST_N`  in  1  reset, synchronous, active-low.
- `RX`  in  1  asynchronous serial line, idle high.
- `DATA`  out  8  last good byte. Holds its value until the next good frame.
- `VALID`  out  1  one-cycle pulse; `DATA` is new this cycle.
- `FRAME_ERR`  out  1  one-cycle pulse; the stop bit was sampled low.
- `BUSY`  out  1  high in every state except IDLE.

## Operation
- `RX` passes through a 2-flop synchroniser (`rx_s`). All decisions use `rx_s`.
- Bit counter `bit_tmr` has width $clog2(`CLKS_PER_BIT`). `HALF` = `CLKS_PER_BIT`/2, rounded down.
- Bit index `bit_idx` is 3 bits. Shift register `shreg` is 8 bits, filled LSB first.
- States:
  - IDLE: `bit_tmr`=0. On `rx_s`==0, go to START.
  - START: count up. At `bit_tmr`==`HALF`-1, sample the line.
    - Sample 0: go to DATA and clear `bit_tmr`.
    - Sample 1: glitch; go to IDLE and report no error.
  - DATA: at `bit_tmr`==`CLKS_PER_BIT`-1, sample into `shreg[bit_idx]`, increment `bit_idx` and clear `bit_tmr`. After `bit_idx`==7 is sampled, go to STOP.
  - STOP: at `bit_tmr`==`CLKS_PER_BIT`-1, sample the line.
    - Sample 1: `DATA`<=`shreg`, pulse `VALID`, go to IDLE.
    - Sample 0: pulse `FRAME_ERR`, leave `DATA` unchanged, go to BREAK.
  - BREAK: wait for `rx_s`==1, then go to IDLE. A held-low line never retriggers a start.
- Any undefined state encoding goes to IDLE on the next cycle.
- `VALID` and `FRAME_ERR` are never high in the same cycle.
- Back-to-back frames: leaving STOP at mid-stop-bit gives half a bit of slack, so the next start edge is caught with no gap needed.

## Timing
- Reset (`RST_N`==0 at a `CLK` edge):
  - state=IDLE.
  - `DATA`=8'h00, `VALID`=0, `FRAME_ERR`=0, `BUSY`=0.
  - Synchroniser flops=1, `bit_tmr`=0, `bit_idx`=0.
- Reset mid-frame abandons the frame with no `VALID` or `FRAME_ERR` pulse. Reception resumes at the next falling edge after reset is released.
- `RX` falling edge to START entry: 3 cycles (2 synchroniser flops + 1 IDLE decision).
- START entry to `VALID`: `HALF` + 9×`CLKS_PER_BIT` cycles, ±1.
- `VALID` and `FRAME_ERR` are registered outputs, high for exactly one cycle.
- There is no backpressure. The consumer must take `DATA` before the next `VALID`, at least 10 bit periods later.

## Configuration
- Macro: `UART_RX_MAJORITY_EN`.
- Defined: a 3-bit history of `rx_s` is kept. Every sample point (start check, data bits, stop bit) uses the 2-of-3 majority of the last three `rx_s` values. This suppresses single-cycle glitches. Sample points and latency are unchanged.
- Undefined: each sample point uses `rx_s` alone. No history register is built.

## Structure
- Package `uart_pkg` holds:
  - the state enum: IDLE, START, DATA, STOP, BREAK;
  - `UART_CLKS_PER_BIT` = 10417, shared with `uart_tx` so both ends stay consistent;
  - `UART_DATA_W` = 8.
- Sub-module `uart_rx_sync` contains the 2-flop synchroniser, plus the majority history when `UART_RX_MAJORITY_EN` is defined. Its outputs are the sampled line value and `rx_s`.
- The FSM, counters and output registers live in `uart_rx`.

## Test plan
- Tests use `CLKS_PER_BIT`=16.
- Send byte 8'hA5, 8N1 → exactly one `VALID` pulse, `DATA`==8'hA5, `FRAME_ERR` never high, `BUSY` low after the pulse.
- Send 8'h00, 8'hFF and 8'h3C back to back with zero idle gap → three `VALID` pulses carrying those values, in order.
- 3-cycle low glitch on idle `RX` → START is entered and then aborted, no `VALID` or `FRAME_ERR`, return to IDLE.
- Frame 8'h55 with stop bit forced low, line held low 40 bit times, then released → one `FRAME_ERR` pulse, `DATA` keeps its previous value, no retrigger while low, next good frame 8'h12 received.
- Assert `RST_N` low for 2 cycles during data bit 4 of a frame → outputs take reset values, the frame is dropped, and the following frame 8'hC3 is received correctly.
- With `UART_RX_MAJORITY_EN` defined, inject a 1-cycle inverted pulse at each mid-bit of 8'h96 → `DATA`==8'h96. Without the macro, the same stimulus corrupts the affected bits.
